// File: rtl/tlb_pkg.sv
// Shared types and constants for the multi-port TLB: packed entry layout,
// page-size encodings and INVTLB op codes.
package tlb_pkg;

  localparam int ENTRY_W = 89;

  localparam logic [5:0] PS_4KB = 6'd12;
  localparam logic [5:0] PS_4MB = 6'd22;

  localparam logic [4:0] INV_OP_ALL0        = 5'd0;
  localparam logic [4:0] INV_OP_ALL1        = 5'd1;
  localparam logic [4:0] INV_OP_G           = 5'd2;
  localparam logic [4:0] INV_OP_NG          = 5'd3;
  localparam logic [4:0] INV_OP_NG_ASID     = 5'd4;
  localparam logic [4:0] INV_OP_NG_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_OP_G_ASID_VA   = 5'd6;

  // MSB -> LSB layout of w_entry / r_entry
  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_match.sv
// Single-entry comparator: valid bit, VPPN (honouring 4MB pages) and an
// optional ASID/global check that the INVTLB path switches off.
module tlb_match
  import tlb_pkg::*;
(
  input  logic        i_e,
  input  logic [18:0] i_ent_vppn,
  input  logic        i_ent_ps4mb,
  input  logic [9:0]  i_ent_asid,
  input  logic        i_ent_g,
  input  logic [18:0] i_vppn,
  input  logic [9:0]  i_asid,
  input  logic        i_asid_en,
  output logic        o_hit
);

  logic w_hi_eq;
  logic w_lo_ok;
  logic w_asid_ok;

  assign w_hi_eq   = (i_ent_vppn[18:10] == i_vppn[18:10]);
  assign w_lo_ok   = i_ent_ps4mb || (i_ent_vppn[9:0] == i_vppn[9:0]);
  assign w_asid_ok = !i_asid_en || i_ent_g || (i_ent_asid == i_asid);
  assign o_hit     = i_e && w_hi_eq && w_lo_ok && w_asid_ok;

endmodule

// File: rtl/tlb_mport.sv
// Fully-associative TLB with NSPORT registered search ports, INVTLB and a
// TLBFILL round-robin pointer. Optional perf counters: TLB_PERF_CNT_EN.
module tlb_mport
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int NSPORT = 2,
  localparam int IDXW  = $clog2(TLBNUM)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NSPORT-1:0]        s_req,
  input  logic [NSPORT*19-1:0]     s_vppn,
  input  logic [NSPORT-1:0]        s_va_bit12,
  input  logic [NSPORT*10-1:0]     s_asid,
  output logic [NSPORT-1:0]        s_rsp_valid,
  output logic [NSPORT-1:0]        s_found,
  output logic [NSPORT*IDXW-1:0]   s_index,
  output logic [NSPORT*20-1:0]     s_ppn,
  output logic [NSPORT*6-1:0]      s_ps,
  output logic [NSPORT*6-1:0]      s_attr,
  input  logic                     we,
  input  logic [IDXW-1:0]          w_index,
  input  logic [ENTRY_W-1:0]       w_entry,
  input  logic [IDXW-1:0]          r_index,
  output logic [ENTRY_W-1:0]       r_entry,
  input  logic                     fill_adv,
  output logic [IDXW-1:0]          fill_index,
  input  logic                     inv_valid,
  input  logic [4:0]               inv_op,
  input  logic [9:0]               inv_asid,
  input  logic [18:0]              inv_vppn,
`ifdef TLB_PERF_CNT_EN
  output logic [NSPORT*32-1:0]     perf_hit,
  output logic [NSPORT*32-1:0]     perf_miss,
`endif
  output logic                     inv_err
);

  tlb_entry_t w_went;
  tlb_entry_t w_rent;
  assign w_went = tlb_entry_t'(w_entry);

  logic [TLBNUM-1:0] r_e;
  logic [TLBNUM-1:0] r_ps4mb;
  logic [TLBNUM-1:0] r_g;
  logic [18:0]       r_vppn  [TLBNUM];
  logic [9:0]        r_asid  [TLBNUM];
  logic [19:0]       r_ppn0  [TLBNUM];
  logic [19:0]       r_ppn1  [TLBNUM];
  logic [5:0]        r_attr0 [TLBNUM];
  logic [5:0]        r_attr1 [TLBNUM];

  logic [TLBNUM-1:0]        w_e_next;
  logic [TLBNUM-1:0]        w_inv_mask;
  logic [TLBNUM-1:0]        w_inv_va;
  logic [TLBNUM-1:0]        w_inv_asid_eq;
  logic [NSPORT*TLBNUM-1:0] w_hit;

  logic [NSPORT-1:0]            w_found;
  logic [NSPORT-1:0][IDXW-1:0]  w_sel;
  logic [NSPORT-1:0]            w_odd;
  logic [NSPORT-1:0][19:0]      w_ppn;
  logic [NSPORT-1:0][5:0]       w_ps;
  logic [NSPORT-1:0][5:0]       w_attr;

  logic [NSPORT-1:0]            r_vld_p1;
  logic [NSPORT-1:0]            r_found_p1;
  logic [NSPORT-1:0][IDXW-1:0]  r_idx_p1;
  logic [NSPORT-1:0][19:0]      r_ppn_p1;
  logic [NSPORT-1:0][5:0]       r_ps_p1;
  logic [NSPORT-1:0][5:0]       r_attr_p1;

  logic [IDXW-1:0] r_fill;
  logic            r_inv_err;

  // Comparator array: one row per search port plus the INVTLB VA row
  for (genvar i = 0; i < TLBNUM; i++) begin : g_ent
    for (genvar k = 0; k < NSPORT; k++) begin : g_port
      tlb_match u_srch (
        .i_e         (r_e[i]),
        .i_ent_vppn  (r_vppn[i]),
        .i_ent_ps4mb (r_ps4mb[i]),
        .i_ent_asid  (r_asid[i]),
        .i_ent_g     (r_g[i]),
        .i_vppn      (s_vppn[k*19 +: 19]),
        .i_asid      (s_asid[k*10 +: 10]),
        .i_asid_en   (1'b1),
        .o_hit       (w_hit[k*TLBNUM + i])
      );
    end

    tlb_match u_inv (
      .i_e         (r_e[i]),
      .i_ent_vppn  (r_vppn[i]),
      .i_ent_ps4mb (r_ps4mb[i]),
      .i_ent_asid  (r_asid[i]),
      .i_ent_g     (r_g[i]),
      .i_vppn      (inv_vppn),
      .i_asid      (inv_asid),
      .i_asid_en   (1'b0),
      .o_hit       (w_inv_va[i])
    );

    assign w_inv_asid_eq[i] = (r_asid[i] == inv_asid);
  end

  always_comb begin
    w_inv_mask = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (inv_op)
        INV_OP_ALL0, INV_OP_ALL1: w_inv_mask[i] = 1'b1;
        INV_OP_G:                 w_inv_mask[i] = r_g[i];
        INV_OP_NG:                w_inv_mask[i] = !r_g[i];
        INV_OP_NG_ASID:           w_inv_mask[i] = !r_g[i] && w_inv_asid_eq[i];
        INV_OP_NG_ASID_VA:        w_inv_mask[i] = !r_g[i] && w_inv_asid_eq[i] && w_inv_va[i];
        INV_OP_G_ASID_VA:         w_inv_mask[i] = (r_g[i] || w_inv_asid_eq[i]) && w_inv_va[i];
        default:                  w_inv_mask[i] = 1'b0;
      endcase
    end
  end

  // A same-cycle write overrides any invalidation of its own slot
  always_comb begin
    w_e_next = r_e;
    if (inv_valid) begin
      w_e_next = r_e & ~w_inv_mask;
    end
    if (we) begin
      w_e_next[w_index] = w_went.e;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_e <= '0;
    end else begin
      r_e <= w_e_next;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && we) begin
      r_vppn[w_index]  <= w_went.vppn;
      r_ps4mb[w_index] <= (w_went.ps == PS_4MB);
      r_asid[w_index]  <= w_went.asid;
      r_g[w_index]     <= w_went.g;
      r_ppn0[w_index]  <= w_went.ppn0;
      r_attr0[w_index] <= {w_went.plv0, w_went.mat0, w_went.d0, w_went.v0};
      r_ppn1[w_index]  <= w_went.ppn1;
      r_attr1[w_index] <= {w_went.plv1, w_went.mat1, w_went.d1, w_went.v1};
    end
  end

  // Lowest-index hit wins: scan downward so the last assignment sticks
  always_comb begin
    for (int k = 0; k < NSPORT; k++) begin
      w_found[k] = 1'b0;
      w_sel[k]   = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
        if (w_hit[k*TLBNUM + i]) begin
          w_found[k] = 1'b1;
          w_sel[k]   = IDXW'(i);
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NSPORT; k++) begin
      w_odd[k]  = r_ps4mb[w_sel[k]] ? s_vppn[k*19 + 9] : s_va_bit12[k];
      w_ppn[k]  = '0;
      w_ps[k]   = PS_4KB;
      w_attr[k] = '0;
      if (w_found[k]) begin
        w_ppn[k]  = w_odd[k] ? r_ppn1[w_sel[k]]  : r_ppn0[w_sel[k]];
        w_attr[k] = w_odd[k] ? r_attr1[w_sel[k]] : r_attr0[w_sel[k]];
        w_ps[k]   = r_ps4mb[w_sel[k]] ? PS_4MB : PS_4KB;
      end
    end
  end

  // ---- stage p1: registered search response ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vld_p1   <= '0;
      r_found_p1 <= '0;
      r_idx_p1   <= '0;
      r_ppn_p1   <= '0;
      r_ps_p1    <= '0;
      r_attr_p1  <= '0;
    end else begin
      r_vld_p1 <= s_req;
      for (int k = 0; k < NSPORT; k++) begin
        if (s_req[k]) begin
          r_found_p1[k] <= w_found[k];
          r_idx_p1[k]   <= w_sel[k];
          r_ppn_p1[k]   <= w_ppn[k];
          r_ps_p1[k]    <= w_ps[k];
          r_attr_p1[k]  <= w_attr[k];
        end
      end
    end
  end

  assign s_rsp_valid = r_vld_p1;
  assign s_found     = r_found_p1;
  assign s_index     = r_idx_p1;
  assign s_ppn       = r_ppn_p1;
  assign s_ps        = r_ps_p1;
  assign s_attr      = r_attr_p1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fill    <= '0;
      r_inv_err <= 1'b0;
    end else begin
      if (fill_adv) begin
        r_fill <= r_fill + 1'b1;
      end
      r_inv_err <= inv_valid && (inv_op > INV_OP_G_ASID_VA);
    end
  end

  assign fill_index = r_fill;
  assign inv_err    = r_inv_err;

  always_comb begin
    w_rent      = '0;
    w_rent.e    = r_e[r_index];
    w_rent.vppn = r_vppn[r_index];
    w_rent.ps   = r_ps4mb[r_index] ? PS_4MB : PS_4KB;
    w_rent.asid = r_asid[r_index];
    w_rent.g    = r_g[r_index];
    w_rent.ppn0 = r_ppn0[r_index];
    {w_rent.plv0, w_rent.mat0, w_rent.d0, w_rent.v0} = r_attr0[r_index];
    w_rent.ppn1 = r_ppn1[r_index];
    {w_rent.plv1, w_rent.mat1, w_rent.d1, w_rent.v1} = r_attr1[r_index];
  end

  assign r_entry = w_rent;

`ifdef TLB_PERF_CNT_EN
  logic [NSPORT-1:0][31:0] r_perf_hit;
  logic [NSPORT-1:0][31:0] r_perf_miss;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_perf_hit  <= '0;
      r_perf_miss <= '0;
    end else begin
      for (int k = 0; k < NSPORT; k++) begin
        if (s_req[k]) begin
          if (w_found[k]) begin
            r_perf_hit[k] <= sat_inc(r_perf_hit[k]);
          end else begin
            r_perf_miss[k] <= sat_inc(r_perf_miss[k]);
          end
        end
      end
    end
  end

  assign perf_hit  = r_perf_hit;
  assign perf_miss = r_perf_miss;
`endif

endmodule

// File: doc/tlb_mport.md
Name: tlb_mport

Overview:
- Parametrised successor to the two-port combinational TLB; a fully-associative LoongArch-style TLB with TLBNUM entries and NSPORT search ports.
- Search results are registered, with a per-port request/response valid pair.
- Adds a dedicated INVTLB operand path, an invalid-op error pulse, E-bit-qualified matching, a reset-cleared table and a round-robin TLBFILL index generator.
- Sits between the IF/MEM address-translation stages and the CSR/TLB-instruction unit.

Parameters:
- TLBNUM, 16, number of entries; power of two, 4..64; IDXW = $clog2(TLBNUM).
- NSPORT, 2, number of independent search ports, 1..4; port k occupies slice k of every flattened s_* bus.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- s_req  in  NSPORT  search request per port
- s_vppn  in  NSPORT*19  VA[31:13] per port
- s_va_bit12  in  NSPORT  VA[12] per port
- s_asid  in  NSPORT*10  ASID per port
- s_rsp_valid  out  NSPORT  registered response valid
- s_found  out  NSPORT  hit
- s_index  out  NSPORT*IDXW  hit entry index
- s_ppn  out  NSPORT*20  selected page PPN
- s_ps  out  NSPORT*6  page size, 12 or 22
- s_attr  out  NSPORT*6  {plv[1:0], mat[1:0], d, v} of the selected page
- we  in  1  write enable
- w_index  in  IDXW  write index
- w_entry  in  ENTRY_W  packed entry to write
- r_index  in  IDXW  read index
- r_entry  out  ENTRY_W  packed entry, combinational read
- fill_adv  in  1  advance fill pointer (TLBFILL executed)
- fill_index  out  IDXW  current TLBFILL target index
- inv_valid  in  1  INVTLB request
- inv_op  in  5  INVTLB op
- inv_asid  in  10  INVTLB ASID operand
- inv_vppn  in  19  INVTLB VA[31:13] operand
- inv_err  out  1  one-cycle pulse, unsupported op

Behaviour:
- Reset (resetn=0 at posedge):
  - all E bits cleared;
  - s_rsp_valid, s_found, s_index, s_ppn, s_ps, s_attr, fill_index and inv_err all become 0;
  - other entry fields are not reset.
- Match for entry i against a port:
  - E[i]=1;
  - vppn[18:10] equal;
  - (ps4MB[i] or vppn[9:0] equal);
  - (ASID equal or G[i]).
- Priority on multiple hits: lowest index wins.
- Page select:
  - 4MB page: vppn[9];
  - 4KB page: va_bit12;
  - selects the ppn0/attr0 or ppn1/attr1 pair.
- Search latency = 1:
  - at a posedge with s_req[k]=1, port k outputs capture the lookup made against pre-edge table contents (read-before-write);
  - s_rsp_valid[k]=1 the following cycle.
- No request: s_rsp_valid[k]=0 next cycle; result outputs hold their last values.
- Miss: s_found=0; s_index, s_ppn and s_attr are 0, s_ps=12.
- Write: at posedge with we=1, entry w_index takes w_entry; the stored ps4MB flag = (w_entry.ps==22).
- Read: r_entry is combinational from r_index. ps reads back as 22 or 12; E reflects the stored bit.
- INVTLB (inv_valid=1) clears E at the posedge for every entry in mask(op):
  - op 0, 1: all entries.
  - op 2: G=1.
  - op 3: G=0.
  - op 4: G=0 and ASID==inv_asid.
  - op 5: G=0, ASID==inv_asid and VA match.
  - op 6: (G=1 or ASID==inv_asid) and VA match.
  - VA match uses the same ps rule as search.
  - op 7..31: no change; inv_err=1 for exactly the next cycle.
- Simultaneous we and inv_valid:
  - the mask is computed on pre-edge state and applied to all entries except w_index;
  - entry w_index takes w_entry.
- fill_index:
  - increments by 1 mod TLBNUM on each posedge with fill_adv=1, wrapping TLBNUM-1 -> 0;
  - fill_adv does not imply a write.
- Reset has priority over we, inv_valid, fill_adv and s_req in the same cycle.

Optional Feature:
- Macro TLB_PERF_CNT_EN.
- Defined:
  - adds outputs perf_hit and perf_miss, each NSPORT*32;
  - per-port counters increment at posedge when s_req[k]=1 (hit or miss by lookup result);
  - counters saturate at 32'hFFFF_FFFF and are cleared by reset.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

Decomposition:
- Package tlb_pkg:
  - ENTRY_W=89;
  - field offsets of w_entry/r_entry, MSB->LSB: e, vppn[18:0], ps[5:0], asid[9:0], g, ppn0[19:0], plv0, mat0, d0, v0, ppn1[19:0], plv1, mat1, d1, v1;
  - PS_4KB=12, PS_4MB=22;
  - INV_OP_* constants 0..6.
- Sub-module tlb_match: single-entry comparator (vppn/ps/asid/g/e, with ASID-compare enable for the INVTLB use).
  - Instanced TLBNUM*(NSPORT+1) times: search ports plus the INVTLB VA path.

Test Plan:
- Reset, then search: s_req=1, any VA -> s_rsp_valid=1 next cycle, s_found=0, s_ps=12.
- Write idx 3 (e=1, vppn=19'h00010, ps=12, asid=5, ppn0=20'hABCDE, ppn1=20'h12345, v0=v1=1), then search port 0 with vppn=19'h00010, va_bit12=1, asid=5 -> next cycle found=1, index=3, ppn=20'h12345.
- Same entry also written at idx 9 -> index=3 (lowest wins). Then write idx 3 with ps=22 and search with vppn[9]=0, va_bit12=1 -> ppn0 selected, s_ps=22.
- Search of idx 3 and write to idx 3 at the same edge -> response carries old contents; a search one cycle later carries new contents.
- INVTLB op5, inv_asid=5, inv_vppn=19'h00010 -> only non-global matching entries lose E. op 9 -> no change, inv_err high for exactly one cycle. we plus op0 in the same cycle -> only w_index remains valid.
- fill_adv held for TLBNUM+1 cycles -> fill_index wraps to 1. resetn=0 mid-sequence -> fill_index=0, all E=0, perf counters 0 (TLB_PERF_CNT_EN).
